// File: rtl/branch_target_buffer_pkg.sv
// btb_pkg: shared types for the branch target buffer.
// Entry bundle, 2-bit counter encodings, allocation value.
package btb_pkg;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  // New entries start weakly taken.
  localparam logic [1:0] CTR_ALLOC = WT;

  // Tag is carried at its widest (pc[31:2]) and
  // zero-extended from the stored width.
  typedef struct packed {
    logic        valid;
    logic [29:0] tag;
    logic [31:0] target;
    logic [1:0]  ctr;
  } btb_entry_t;

endpackage

// File: rtl/branch_target_buffer_if.sv
// Fetch lookup + execute training bundle for the BTB.
// master: pipeline side; slave: the BTB itself.
interface branch_target_buffer_if;

  logic [31:0] pcF;
  logic        bPredictedTakenF;
  logic [31:0] predTargetF;
  logic        btbHitF;
  logic        clear;
  logic        controlXferE;
  logic        pcSelE;
  logic        btbUpdateE;
  logic [31:0] pcE;
  logic [31:0] btbTargetE;
  logic        validInstE;

  modport master (
    output pcF,
    output clear,
    output controlXferE,
    output pcSelE,
    output btbUpdateE,
    output pcE,
    output btbTargetE,
    output validInstE,
    input  bPredictedTakenF,
    input  predTargetF,
    input  btbHitF
  );

  modport slave (
    input  pcF,
    input  clear,
    input  controlXferE,
    input  pcSelE,
    input  btbUpdateE,
    input  pcE,
    input  btbTargetE,
    input  validInstE,
    output bPredictedTakenF,
    output predTargetF,
    output btbHitF
  );

endinterface

// File: rtl/branch_target_buffer_ctr_next.sv
// btb_ctr_next: 2-bit saturating direction counter step.
// ctr_i/taken_i in, ctr_o next value out.
module btb_ctr_next
  import btb_pkg::*;
(
  input  logic [1:0] ctr_i,
  input  logic       taken_i,
  output logic [1:0] ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    unique case (1'b1)
      (taken_i && ctr_i != ST):
        ctr_o = ctr_i + 2'd1;
      (!taken_i && ctr_i != SNT):
        ctr_o = ctr_i - 2'd1;
      default: ;
    endcase
  end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with 2-bit counters; clk, rst plus bus
// (slave). Optional same-cycle forwarding: BTB_BYPASS_EN.
module branch_target_buffer
  import btb_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int TAG_W   = 30 - $clog2(ENTRIES)
) (
  input logic clk,
  input logic rst,
  branch_target_buffer_if.slave bus
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic [ENTRIES-1:0]      valid_q, valid_d;
  logic [ENTRIES-1:0][1:0] ctr_q, ctr_d;
  logic [TAG_W-1:0]        tag_q [ENTRIES];
  logic [31:0]             tgt_q [ENTRIES];

  logic [IDX_W-1:0] idx_f, idx_e;
  logic [29:0]      tag30_f, tag30_e;

  assign idx_f   = bus.pcF[IDX_W+1:2];
  assign idx_e   = bus.pcE[IDX_W+1:2];
  assign tag30_f = 30'(bus.pcF[31:IDX_W+2]);
  assign tag30_e = 30'(bus.pcE[31:IDX_W+2]);

  btb_entry_t rd, lk, ent_e, wr;

  always_comb begin
    rd.valid  = valid_q[idx_f];
    rd.tag    = 30'(tag_q[idx_f]);
    rd.target = tgt_q[idx_f];
    rd.ctr    = ctr_q[idx_f];
  end

  always_comb begin
    ent_e.valid  = valid_q[idx_e];
    ent_e.tag    = 30'(tag_q[idx_e]);
    ent_e.target = tgt_q[idx_e];
    ent_e.ctr    = ctr_q[idx_e];
  end

  logic hit_e, upd, we;
  logic [1:0] ctr_nx;

  assign hit_e = ent_e.valid
               && (ent_e.tag == tag30_e);
  assign upd   = bus.controlXferE
               && bus.validInstE;

  // A PC-relative taken branch always writes;
  // a not-taken one only weakens an existing hit.
  assign we = upd && (bus.btbUpdateE
            || (!bus.pcSelE && hit_e));

  btb_ctr_next u_ctr (
    .ctr_i   (ent_e.ctr),
    .taken_i (bus.btbUpdateE),
    .ctr_o   (ctr_nx)
  );

  always_comb begin
    wr.valid  = 1'b1;
    wr.tag    = tag30_e;
    wr.target = bus.btbUpdateE
              ? bus.btbTargetE
              : ent_e.target;
    wr.ctr    = hit_e ? ctr_nx : CTR_ALLOC;
  end

  always_comb begin
    valid_d = valid_q;
    ctr_d   = ctr_q;
    if (we) begin
      valid_d[idx_e] = wr.valid;
      ctr_d[idx_e]   = wr.ctr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.clear) begin
      valid_q <= '0;
      ctr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ctr_q   <= ctr_d;
    end
  end

  // Tag/target carry no reset; valid guards them.
  always_ff @(posedge clk) begin
    if (we && !rst && !bus.clear) begin
      tag_q[idx_e] <= bus.pcE[31:IDX_W+2];
      tgt_q[idx_e] <= wr.target;
    end
  end

`ifdef BTB_BYPASS_EN
  logic byp;
  assign byp = we && !bus.clear && !rst
             && (idx_e == idx_f)
             && (tag30_e == tag30_f);

  always_comb begin
    lk = rd;
    if (byp) lk = wr;
  end
`else
  assign lk = rd;
`endif

  logic hit_f;
  // Forced low in reset so the array's
  // power-up contents never leak out.
  assign hit_f = lk.valid && !rst
               && (lk.tag == tag30_f);

  assign bus.btbHitF          = hit_f;
  assign bus.bPredictedTakenF = hit_f && lk.ctr[1];
  assign bus.predTargetF      = hit_f
                              ? lk.target : 32'd0;

  logic unused_bits;
  assign unused_bits = ^{bus.pcF[1:0], bus.pcE[1:0],
                         wr.tag, lk.ctr[0]};

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed self-checking bench for branch_target_buffer.
// ENTRIES=64; lookups sampled #1 after input changes.
module tb_branch_target_buffer;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  branch_target_buffer_if bus ();

  branch_target_buffer #(.ENTRIES(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h",
               tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.clear        = 1'b0;
    bus.controlXferE = 1'b0;
    bus.pcSelE       = 1'b0;
    bus.btbUpdateE   = 1'b0;
    bus.validInstE   = 1'b0;
    bus.pcE          = 32'd0;
    bus.btbTargetE   = 32'd0;
  endtask

  task automatic set_upd(input logic [31:0] pc,
                         input logic [31:0] tgt,
                         input logic x,
                         input logic v,
                         input logic sel,
                         input logic bu);
    bus.pcE          = pc;
    bus.btbTargetE   = tgt;
    bus.controlXferE = x;
    bus.validInstE   = v;
    bus.pcSelE       = sel;
    bus.btbUpdateE   = bu;
  endtask

  task automatic upd(input logic [31:0] pc,
                     input logic [31:0] tgt,
                     input logic sel,
                     input logic bu);
    set_upd(pc, tgt, 1'b1, 1'b1, sel, bu);
    cyc();
    idle();
  endtask

  task automatic look(input string nm,
                      input logic [31:0] pc,
                      input logic h,
                      input logic tk,
                      input logic [31:0] tgt);
    bus.pcF = pc;
    #1;
    chk({nm, ".hit"}, 32'(bus.btbHitF), 32'(h));
    chk({nm, ".tkn"},
        32'(bus.bPredictedTakenF), 32'(tk));
    chk({nm, ".tgt"}, bus.predTargetF, tgt);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    idle();
    bus.pcF = 32'h100;
    rst = 1'b1;
    #1;
    look("in_rst0", 32'h100, 0, 0, 0);
    cyc();
    cyc();
    look("in_rst", 32'h100, 0, 0, 0);
    rst = 1'b0;
    cyc();
    look("post_rst", 32'h100, 0, 0, 0);

    // allocate: WT
    upd(32'h100, 32'h180, 1, 1);
    look("alloc", 32'h100, 1, 1, 32'h180);
    // WT -> WNT -> SNT -> SNT
    upd(32'h100, 32'h0, 0, 0);
    look("nt1", 32'h100, 1, 0, 32'h180);
    upd(32'h100, 32'h0, 0, 0);
    look("nt2", 32'h100, 1, 0, 32'h180);
    upd(32'h100, 32'h0, 0, 0);
    look("nt3", 32'h100, 1, 0, 32'h180);
    // SNT -> WNT, target rewritten
    upd(32'h100, 32'h1c0, 1, 1);
    look("t1", 32'h100, 1, 0, 32'h1c0);
    // WNT -> WT -> ST -> ST
    upd(32'h100, 32'h1c0, 1, 1);
    look("t2", 32'h100, 1, 1, 32'h1c0);
    upd(32'h100, 32'h1c0, 1, 1);
    upd(32'h100, 32'h1c0, 1, 1);
    // ST -> WT: still taken only if ST saturated
    upd(32'h100, 32'h0, 0, 0);
    look("st_sat", 32'h100, 1, 1, 32'h1c0);

    // alias at index 0, tag 2 replaces tag 1
    upd(32'h200, 32'h280, 1, 1);
    look("alias_old", 32'h100, 0, 0, 0);
    look("alias_new", 32'h200, 1, 1, 32'h280);

    // JALR: no allocate, no change
    upd(32'h300, 32'h999, 1, 0);
    look("jalr_miss", 32'h300, 0, 0, 0);
    upd(32'h200, 32'h999, 1, 0);
    look("jalr_hit", 32'h200, 1, 1, 32'h280);

    // not-taken miss: no allocate
    upd(32'h304, 32'h0, 0, 0);
    look("nt_miss", 32'h304, 0, 0, 0);

    // invalid or non-branch slots ignored
    set_upd(32'h304, 32'h500, 1, 0, 1, 1);
    cyc();
    set_upd(32'h304, 32'h500, 0, 1, 1, 1);
    cyc();
    idle();
    look("novalid", 32'h304, 0, 0, 0);
    look("novalid0", 32'h200, 1, 1, 32'h280);

    // second index, high-tag mismatch
    upd(32'h104, 32'h140, 1, 1);
    look("idx1", 32'h104, 1, 1, 32'h140);
    look("hi_tag", 32'h8000_0104, 0, 0, 0);
    look("idx0_kept", 32'h200, 1, 1, 32'h280);

    // clear wins over a same-cycle update
    bus.clear = 1'b1;
    set_upd(32'h400, 32'h480, 1, 1, 1, 1);
    cyc();
    idle();
    look("clr_400", 32'h400, 0, 0, 0);
    look("clr_200", 32'h200, 0, 0, 0);
    look("clr_104", 32'h104, 0, 0, 0);

    // same-cycle lookup of the updated entry
    set_upd(32'h400, 32'h480, 1, 1, 1, 1);
`ifdef BTB_BYPASS_EN
    look("same_cyc", 32'h400, 1, 1, 32'h480);
`else
    look("same_cyc", 32'h400, 0, 0, 0);
`endif
    cyc();
    idle();
    look("after_byp", 32'h400, 1, 1, 32'h480);

    // reset clears again
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    look("rst2", 32'h400, 0, 0, 0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule

// File: doc/branch_target_buffer.md
# branch_target_buffer

Direct-mapped branch target buffer with 2-bit saturating direction counters; the fetch-side prediction source for the pipeline. Each cycle it answers a combinational lookup for the fetch PC with a taken prediction and target. It is trained by the execute stage's resolved control-transfer outputs (controlXfer, pcSel, btbUpdate, btbTarget, pc, validInst), closing the loop that carries bPredictedTaken back into execute.

## Interface
Parameters:
- ENTRIES, 64, number of entries; power of two, ≥2; IDX_W = $clog2(ENTRIES)
- TAG_W, 30-IDX_W, stored tag width (pc[31:IDX_W+2])

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, synchronous and active-high
- pcF  in  32  fetch PC to look up
- bPredictedTakenF  out  1  hit AND counter[1]
- predTargetF  out  32  stored target of indexed entry when hit, else 0
- btbHitF  out  1  indexed entry valid and tag matches
- clear  in  1  invalidate all entries (fence.i)
- controlXferE  in  1  execute holds a branch or jump
- pcSelE  in  1  resolved taken
- btbUpdateE  in  1  taken and not JALR; target is PC-relative
- pcE  in  32  PC of the execute instruction
- btbTargetE  in  32  pc+imm target from execute
- validInstE  in  1  execute holds a real instruction (pc ≠ 0)

## Operation
- Index = pc[IDX_W+1:2], tag = pc[31:IDX_W+2]; pc[1:0] ignored.
- Entry: valid, tag, target[31:0], ctr[1:0]. Counter states: SNT=00, WNT=01, WT=10, ST=11.
- Lookup (combinational, array read): hit = valid & tag match; outputs as above. All outputs are 0 on miss.
- Update enable upd = controlXferE & validInstE. Cases at posedge:
  - upd & btbUpdateE & hit: ctr saturating +1 (ST stays ST); target rewritten with btbTargetE.
  - upd & btbUpdateE & miss: allocate (overwrite any occupant): valid=1, tag, target=btbTargetE, ctr=WT.
  - upd & !pcSelE & hit: ctr saturating −1 (SNT stays SNT); valid stays 1; target unchanged.
  - upd & !pcSelE & miss: no change.
  - upd & pcSelE & !btbUpdateE (JALR): no change.
- Priority: rst > clear > update. clear in the same cycle as an update discards the update.
- rst and clear zero every valid bit and ctr; tag/target are not reset.

## Timing
- Lookup latency 0 cycles (combinational from pcF).
- An update is visible to lookups from the cycle after its posedge.
- A same-cycle lookup of the index being updated returns the pre-update contents, unless BTB_BYPASS_EN is defined.
- Reset values: bPredictedTakenF=0, predTargetF=0, btbHitF=0 for any pcF during and after reset until allocation.
- One update per cycle max; no backpressure, no handshakes. Execute flush gating is the producer's job (flushed slots arrive with controlXferE=0 or validInstE=0).

## Configuration
- BTB_BYPASS_EN defined: if upd is active and the index and tag of pcE equal those of pcF, lookup outputs reflect the post-update entry in the same cycle. On an allocate, for example, btbHitF=1 and bPredictedTakenF=1 with predTargetF=btbTargetE. A cycle with clear asserted suppresses the bypass.
- Undefined: no forwarding path; the lookup reads only the registered array.

## Structure
- Shared package btb_pkg: entry struct typedef, counter localparams SNT/WNT/WT/ST, and the allocation counter value (WT).
- One sub-module is natural: btb_ctr_next, a combinational 2-bit saturating next-state for the inputs ctr and taken.
- The array is registers, not a RAM macro, because reads are asynchronous.

## Test plan
All cases use ENTRIES=64.
- After reset, lookup pcF=0x100 -> btbHitF=0, bPredictedTakenF=0, predTargetF=0.
- Taken branch pcE=0x100, btbTargetE=0x180, btbUpdateE=1 -> next cycle pcF=0x100 gives hit, taken, target 0x180, ctr=WT.
- Then two not-taken resolutions at 0x100 -> ctr WT→WNT→SNT; hit=1, bPredictedTakenF=0. A third not-taken stays at SNT.
- Alias: allocate 0x100, then taken at 0x200 (same index 0, tag 2) -> pcF=0x100 misses, pcF=0x200 hits target 0x200's btbTargetE.
- JALR (pcSelE=1, btbUpdateE=0) at 0x300, and validInstE=0 with a taken branch -> no entries change.
- clear asserted together with a taken update at 0x400 -> all lookups miss next cycle. With BTB_BYPASS_EN and no clear, allocating at pcE=pcF=0x400 gives hit in the same cycle.
